// File: rtl/intc_pkg.sv
// intc_pkg
//  Shared definitions for the vectored interrupt controller: register word
//  offsets (selected by a[3:2]), FSM state encodings and a helper that packs
//  the STAT read word.
//  Optional feature macro used by intc_vec: INTC_TRIG_CFG_EN.
package intc_pkg;

  localparam logic [1:0] INTC_REG_MASK = 2'd0;
  localparam logic [1:0] INTC_REG_PEND = 2'd1;
  localparam logic [1:0] INTC_REG_STAT = 2'd2;
  localparam logic [1:0] INTC_REG_TRIG = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_ACK   = 2'd2
  } intc_state_e;

  // STAT word: active flag on bit 31, issued source id in the low byte.
  function automatic logic [31:0] intcStatWord(input logic active, input logic [7:0] id);
    return {active, 23'b0, id};
  endfunction

endpackage

// File: rtl/intc_prio_enc.sv
// intc_prio_enc
//  Combinational priority encoder: reports whether any bit of the input vector
//  is set and the index of the lowest set bit (bit 0 = highest priority).
// Ports:
//  vec_i  in   N_SRC  request vector
//  any_o  out  1      at least one bit set
//  idx_o  out  IDW    index of the lowest set bit (0 when none set)
module intc_prio_enc #(
  parameter int N_SRC = 8,
  parameter int IDW   = 3
) (
  input  logic [N_SRC-1:0] vec_i,
  output logic             any_o,
  output logic [IDW-1:0]   idx_o
);

  assign any_o = |vec_i;

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    idx_o = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = IDW'(i);
    end
  end

endmodule

// File: rtl/intc_vec.sv
// intc_vec
//  Parametrised vectored interrupt controller. Synchronises N_SRC request
//  lines, applies a per-source mask, latches pending requests and issues them
//  one at a time to the core with a request/reply handshake, lowest index first.
//  Optional feature: define INTC_TRIG_CFG_EN to add the TRIG register
//  (per-source level/edge select); without it every source is edge-triggered.
// Ports:
//  clk        in   1      system clock
//  rst_n      in   1      asynchronous active-low reset
//  irq_src    in   N_SRC  raw request lines, active-high
//  interrupt  out  1      interrupt request to core
//  int_id     out  IDW    source index of the issued interrupt
//  int_reply  in   1      core acknowledge (level)
//  a          in   4      word address, a[3:2] selects MASK/PEND/STAT/TRIG
//  d          in   32     write data
//  we         in   1      register write strobe
//  spo        out  32     combinational read data
module intc_vec
  import intc_pkg::*;
#(
  parameter int N_SRC = 8,
  parameter int IDW   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] irq_src,
  output logic             interrupt,
  output logic [IDW-1:0]   int_id,
  input  logic             int_reply,
  input  logic [3:0]       a,
  input  logic [31:0]      d,
  input  logic             we,
  output logic [31:0]      spo
);

  logic [N_SRC-1:0] src_q, src_qq;
  logic             rep_q;
  logic [N_SRC-1:0] mask_q;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [N_SRC-1:0] level_sel;
  logic [N_SRC-1:0] set_vec, w1c_vec, issue_clr;
  logic             pend_any;
  logic [IDW-1:0]   pend_idx;
  intc_state_e      state_q;
  logic             interrupt_q;
  logic [IDW-1:0]   int_id_q;
  logic             wr_mask, wr_pend;
  logic [31:0]      mask_rd, pend_rd, trig_rd;
  logic [7:0]       id_ext;
  logic             unused_bits;

  // Address low bits and data bits above N_SRC carry no meaning here.
  assign unused_bits = ^{a[1:0], d};

  assign wr_mask = we && (a[3:2] == INTC_REG_MASK);
  assign wr_pend = we && (a[3:2] == INTC_REG_PEND);

  // Two-stage capture of the request lines gives a clean edge detector;
  // the reply only needs a single stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q  <= '0;
      src_qq <= '0;
      rep_q  <= 1'b0;
    end else begin
      src_q  <= irq_src;
      src_qq <= src_q;
      rep_q  <= int_reply;
    end
  end

  // Everything starts masked so nothing fires before software configures it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mask_q <= '1;
    else if (wr_mask) mask_q <= d[N_SRC-1:0];
  end

`ifdef INTC_TRIG_CFG_EN
  logic [N_SRC-1:0] trig_q;
  logic             wr_trig;

  assign wr_trig = we && (a[3:2] == INTC_REG_TRIG);

  // Per-source trigger select: 1 = level, 0 = edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) trig_q <= '0;
    else if (wr_trig) trig_q <= d[N_SRC-1:0];
  end

  assign level_sel = trig_q;
`else
  assign level_sel = '0;
`endif

  // Masked requests are dropped here, so later unmasking cannot revive them.
  assign set_vec = ~mask_q & ((level_sel & src_q) | (~level_sel & src_q & ~src_qq));
  assign w1c_vec = wr_pend ? d[N_SRC-1:0] : '0;

  intc_prio_enc #(
    .N_SRC (N_SRC),
    .IDW   (IDW)
  ) u_prio (
    .vec_i (pend_q),
    .any_o (pend_any),
    .idx_o (pend_idx)
  );

  // The bit being issued is consumed in the same cycle the FSM leaves IDLE.
  always_comb begin
    issue_clr = '0;
    if (state_q == ST_IDLE && pend_any) issue_clr[pend_idx] = 1'b1;
  end

  // New requests are ORed in last so a set beats a clear in the same cycle.
  assign pend_d = (pend_q & ~w1c_vec & ~issue_clr) | set_vec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= '0;
    else pend_q <= pend_d;
  end

  // Handshake FSM. ACK waits for the reply to drop so a long reply cannot
  // trigger a second issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      interrupt_q <= 1'b0;
      int_id_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pend_any) begin
            int_id_q    <= pend_idx;
            interrupt_q <= 1'b1;
            state_q     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (rep_q) begin
            interrupt_q <= 1'b0;
            state_q     <= ST_ACK;
          end
        end
        ST_ACK: begin
          if (!rep_q) state_q <= ST_IDLE;
        end
        default: begin
          interrupt_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign interrupt = interrupt_q;
  assign int_id    = int_id_q;

  // Zero-extend the per-source registers to the 32-bit bus.
  always_comb begin
    mask_rd = '0;
    pend_rd = '0;
    trig_rd = '0;
    id_ext  = '0;
    mask_rd[N_SRC-1:0] = mask_q;
    pend_rd[N_SRC-1:0] = pend_q;
`ifdef INTC_TRIG_CFG_EN
    trig_rd[N_SRC-1:0] = trig_q;
`endif
    id_ext[IDW-1:0] = int_id_q;
  end

  always_comb begin
    spo = '0;
    case (a[3:2])
      INTC_REG_MASK: spo = mask_rd;
      INTC_REG_PEND: spo = pend_rd;
      INTC_REG_STAT: spo = intcStatWord(state_q == ST_ISSUE, id_ext);
      INTC_REG_TRIG: spo = trig_rd;
      default:       spo = '0;
    endcase
  end

endmodule

// File: tb/tb_intc_vec.sv
// tb_intc_vec
//  Directed testbench for intc_vec with N_SRC=8, IDW=3. Inputs are driven and
//  outputs sampled 1ns after each rising clock edge.
module tb_intc_vec;
  import intc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  irq_src;
  logic        interrupt;
  logic [2:0]  int_id;
  logic        int_reply;
  logic [3:0]  a;
  logic [31:0] d;
  logic        we;
  logic [31:0] spo;

  int checks = 0;
  int errors = 0;

  intc_vec #(.N_SRC(8), .IDW(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .irq_src   (irq_src),
    .interrupt (interrupt),
    .int_id    (int_id),
    .int_reply (int_reply),
    .a         (a),
    .d         (d),
    .we        (we),
    .spo       (spo)
  );

  // 10ns clock.
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s got 0x%08h want 0x%08h", tag, observed, expected);
    end
  endtask

  // Advance n rising edges and settle 1ns after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive a request pattern for n cycles, then release all lines.
  task automatic applyStimulus(input logic [7:0] pattern, input int n);
    irq_src = pattern;
    tick(n);
    irq_src = '0;
  endtask

  task automatic writeReg(input logic [1:0] sel, input logic [31:0] val);
    a  = {sel, 2'b00};
    d  = val;
    we = 1'b1;
    tick(1);
    we = 1'b0;
  endtask

  task automatic readReg(input logic [1:0] sel, input logic [1:0] lowBits, output logic [31:0] val);
    a = {sel, lowBits};
    #1;
    val = spo;
  endtask

  // Full reply pulse: two cycles high, then back to IDLE two edges after release.
  task automatic handshake();
    int_reply = 1'b1;
    tick(2);
    checkOutput("handshake drop", {31'b0, interrupt}, 32'h0);
    int_reply = 1'b0;
    tick(2);
  endtask

  task automatic waitIrq(output logic seen);
    seen = 1'b0;
    for (int k = 0; k < 12 && !seen; k++) begin
      tick(1);
      if (interrupt) seen = 1'b1;
    end
  endtask

  logic [31:0] rd;
  logic        seen;

  initial begin
    rst_n     = 1'b0;
    irq_src   = '0;
    int_reply = 1'b0;
    a         = '0;
    d         = '0;
    we        = 1'b0;

    // Reset state
    tick(3);
    checkOutput("rst interrupt", {31'b0, interrupt}, 32'h0);
    checkOutput("rst int_id", {29'b0, int_id}, 32'h0);
    rst_n = 1'b1;
    tick(1);
    readReg(INTC_REG_MASK, 2'b00, rd);
    checkOutput("rst MASK", rd, 32'h0000_00FF);
    readReg(INTC_REG_MASK, 2'b11, rd);
    checkOutput("rst MASK lowbits", rd, 32'h0000_00FF);
    readReg(INTC_REG_PEND, 2'b00, rd);
    checkOutput("rst PEND", rd, 32'h0);
    readReg(INTC_REG_STAT, 2'b00, rd);
    checkOutput("rst STAT", rd, 32'h0);
    readReg(INTC_REG_TRIG, 2'b00, rd);
    checkOutput("rst TRIG", rd, 32'h0);

    // Masked pulse is discarded
    tick(1);
    applyStimulus(8'h08, 1);
    tick(4);
    checkOutput("t1 masked irq", {31'b0, interrupt}, 32'h0);
    readReg(INTC_REG_PEND, 2'b00, rd);
    checkOutput("t1 masked PEND", rd, 32'h0);

    // Single edge source, latency and long reply
    writeReg(INTC_REG_MASK, 32'h0);
    readReg(INTC_REG_MASK, 2'b00, rd);
    checkOutput("t2 MASK cleared", rd, 32'h0);
    tick(1);
    irq_src = 8'h20;
    tick(1);
    irq_src = '0;
    checkOutput("t2 edge1 irq", {31'b0, interrupt}, 32'h0);
    tick(1);
    checkOutput("t2 edge2 irq", {31'b0, interrupt}, 32'h0);
    readReg(INTC_REG_PEND, 2'b00, rd);
    checkOutput("t2 edge2 PEND", rd, 32'h20);
    tick(1);
    checkOutput("t2 edge3 irq", {31'b0, interrupt}, 32'h1);
    checkOutput("t2 edge3 id", {29'b0, int_id}, 32'd5);
    readReg(INTC_REG_PEND, 2'b00, rd);
    checkOutput("t2 PEND consumed", rd, 32'h0);
    readReg(INTC_REG_STAT, 2'b00, rd);
    checkOutput("t2 STAT active", rd, 32'h8000_0005);
    int_reply = 1'b1;
    tick(1);
    checkOutput("t2 r+1 irq", {31'b0, interrupt}, 32'h1);
    tick(1);
    checkOutput("t2 r+2 irq", {31'b0, interrupt}, 32'h0);
    tick(2);
    checkOutput("t2 r+4 irq", {31'b0, interrupt}, 32'h0);
    int_reply = 1'b0;
    tick(4);
    checkOutput("t2 no reissue", {31'b0, interrupt}, 32'h0);
    readReg(INTC_REG_STAT, 2'b00, rd);
    checkOutput("t2 STAT idle id held", rd, 32'h0000_0005);

    // Two simultaneous sources, strict priority
    tick(1);
    applyStimulus(8'h42, 1);
    tick(2);
    checkOutput("t3 first irq", {31'b0, interrupt}, 32'h1);
    checkOutput("t3 first id", {29'b0, int_id}, 32'd1);
    readReg(INTC_REG_PEND, 2'b00, rd);
    checkOutput("t3 PEND left", rd, 32'h40);
    tick(1);
    int_reply = 1'b1;
    tick(2);
    checkOutput("t3 reply drop", {31'b0, interrupt}, 32'h0);
    int_reply = 1'b0;
    readReg(INTC_REG_STAT, 2'b00, rd);
    checkOutput("t3 STAT gap r+2", rd, 32'h0000_0001);
    tick(1);
    readReg(INTC_REG_STAT, 2'b00, rd);
    checkOutput("t3 STAT gap r+3", rd, 32'h0000_0001);
    tick(1);
    checkOutput("t3 gap irq", {31'b0, interrupt}, 32'h0);
    tick(1);
    checkOutput("t3 second irq", {31'b0, interrupt}, 32'h1);
    checkOutput("t3 second id", {29'b0, int_id}, 32'd6);
    handshake();
    tick(3);
    checkOutput("t3 quiet", {31'b0, interrupt}, 32'h0);

    // W1C while busy, and set beating W1C
    applyStimulus(8'h01, 1);
    tick(2);
    checkOutput("t4 busy irq", {31'b0, interrupt}, 32'h1);
    checkOutput("t4 busy id", {29'b0, int_id}, 32'd0);
    applyStimulus(8'h04, 1);
    tick(1);
    readReg(INTC_REG_PEND, 2'b00, rd);
    checkOutput("t4 PEND bit2", rd, 32'h04);
    checkOutput("t4 no preempt", {29'b0, int_id}, 32'd0);
    writeReg(INTC_REG_PEND, 32'h04);
    readReg(INTC_REG_PEND, 2'b00, rd);
    checkOutput("t4 W1C", rd, 32'h0);
    tick(1);
    irq_src = 8'h04;
    tick(1);
    irq_src = '0;
    a  = {INTC_REG_PEND, 2'b00};
    d  = 32'h04;
    we = 1'b1;
    tick(1);
    we = 1'b0;
    readReg(INTC_REG_PEND, 2'b00, rd);
    checkOutput("t4 set wins", rd, 32'h04);
    writeReg(INTC_REG_PEND, 32'h04);
    readReg(INTC_REG_PEND, 2'b00, rd);
    checkOutput("t4 W1C again", rd, 32'h0);
    tick(1);
    handshake();
    tick(4);
    checkOutput("t4 no issue", {31'b0, interrupt}, 32'h0);

`ifdef INTC_TRIG_CFG_EN
    // Level source repeats until masked
    writeReg(INTC_REG_TRIG, 32'h01);
    readReg(INTC_REG_TRIG, 2'b00, rd);
    checkOutput("t5 TRIG", rd, 32'h01);
    tick(1);
    irq_src = 8'h01;
    tick(3);
    checkOutput("t5 first irq", {31'b0, interrupt}, 32'h1);
    checkOutput("t5 first id", {29'b0, int_id}, 32'd0);
    for (int n = 0; n < 2; n++) begin
      handshake();
      waitIrq(seen);
      checkOutput("t5 reissue", {31'b0, seen}, 32'h1);
      checkOutput("t5 reissue id", {29'b0, int_id}, 32'd0);
    end
    writeReg(INTC_REG_MASK, 32'h01);
    checkOutput("t5 mask keeps irq", {31'b0, interrupt}, 32'h1);
    writeReg(INTC_REG_PEND, 32'h01);
    readReg(INTC_REG_PEND, 2'b00, rd);
    checkOutput("t5 PEND masked", rd, 32'h0);
    tick(1);
    handshake();
    tick(8);
    checkOutput("t5 stopped", {31'b0, interrupt}, 32'h0);
    irq_src = '0;
    writeReg(INTC_REG_TRIG, 32'h0);
    writeReg(INTC_REG_MASK, 32'h0);
    tick(2);
`endif

    // Reset in the middle of a handshake
    applyStimulus(8'h18, 1);
    tick(2);
    checkOutput("t6 irq", {31'b0, interrupt}, 32'h1);
    checkOutput("t6 id", {29'b0, int_id}, 32'd3);
    readReg(INTC_REG_PEND, 2'b00, rd);
    checkOutput("t6 PEND before", rd, 32'h10);
    rst_n = 1'b0;
    #1;
    checkOutput("t6 async drop", {31'b0, interrupt}, 32'h0);
    checkOutput("t6 id reset", {29'b0, int_id}, 32'd0);
    #1;
    rst_n = 1'b1;
    tick(1);
    readReg(INTC_REG_MASK, 2'b00, rd);
    checkOutput("t6 MASK", rd, 32'h0000_00FF);
    readReg(INTC_REG_PEND, 2'b00, rd);
    checkOutput("t6 PEND", rd, 32'h0);
    readReg(INTC_REG_STAT, 2'b00, rd);
    checkOutput("t6 STAT", rd, 32'h0);
    tick(4);
    checkOutput("t6 quiet", {31'b0, interrupt}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
